// File: rtl/spi_master_core_if.sv
// -----------------------------------------------------------------------------
// spi_master_core_if
//   Bundles the parallel start/done handshake and the serial SPI pins of one
//   spi_master_core instance.
//   master modport : the core's view (drives sclk/cs_n/mosi and the results).
//   slave modport  : the surrounding logic / SPI device view.
//   Signals:
//     start, tx_data   - transfer request and word to send
//     rx_data          - last received word
//     busy, done       - transfer in progress / one-cycle completion pulse
//     sclk, cs_n, mosi - SPI clock, chip select (active low), serial out
//     miso             - serial in
// -----------------------------------------------------------------------------
interface spi_master_core_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, cs_n, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
//   Mode-0 (CPOL=0, CPHA=0), MSB-first SPI shift engine. The divided clock
//   sclk_div is sampled in the clk domain; its edges pace every SPI action,
//   so sclk follows sclk_div with one clk of latency.
//   Ports:
//     clk      - system clock, rising edge
//     rst_n    - asynchronous active-low reset
//     sclk_div - divided timing reference (each level >= 2 clk)
//     bus      - handshake + SPI pins (spi_master_core_if.master)
// -----------------------------------------------------------------------------
module spi_master_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk_div,
  spi_master_core_if.master   bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  sclk_div_q;
  // The MSB goes straight to mosi at load time, so only the remaining
  // DATA_WIDTH-1 bits need to be kept for shifting.
  logic [DATA_WIDTH-2:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic rise_ev, fall_ev;
  assign rise_ev = sclk_div & ~sclk_div_q;
  assign fall_ev = ~sclk_div & sclk_div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sclk_div_q <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_div_q <= sclk_div;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // The done cycle is still IDLE; a request there is dropped so that
        // a held start restarts one cycle later and cs_n gets a gap.
        if (bus.start && !done_q) begin
          tx_shift_d = bus.tx_data[DATA_WIDTH-2:0];
          mosi_d     = bus.tx_data[DATA_WIDTH-1];
          cs_n_d     = 1'b0;
          bit_cnt_d  = CW'(DATA_WIDTH - 1);
          busy_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        // Waiting for a fall guarantees a half period of cs_n setup before
        // the first sclk rise.
        if (fall_ev) state_d = XFER;
      end
      XFER: begin
        if (rise_ev) begin
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
        end else if (fall_ev) begin
          sclk_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = HOLD;
          end else begin
            bit_cnt_d  = bit_cnt_q - CW'(1);
            mosi_d     = tx_shift_q[DATA_WIDTH-2];
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      HOLD: begin
        // Keep cs_n low for the final half period after the last fall.
        if (rise_ev) begin
          cs_n_d    = 1'b1;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sclk    = sclk_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
module tb_spi_master_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Free-running divider model: sclk_div toggles every `half` clk cycles.
  int   half = 2;
  int   dcnt = 0;
  logic sclk_div = 1'b0;
  always @(posedge clk) begin
    if (dcnt >= half - 1) begin dcnt <= 0; sclk_div <= ~sclk_div; end
    else dcnt <= dcnt + 1;
  end

  spi_master_core_if #(.DATA_WIDTH(8))  b8 ();
  spi_master_core_if #(.DATA_WIDTH(16)) b16 ();

  spi_master_core #(.DATA_WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .sclk_div(sclk_div), .bus(b8));
  spi_master_core #(.DATA_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .sclk_div(sclk_div), .bus(b16));

  int checks = 0;
  int fails  = 0;

  // miso source for the 8-bit core: 0 loopback, 1 tied high, 2 slave word
  int         mode = 0;
  logic [7:0] slave_w = '0;
  int         r8 = 0, d8 = 0, viol = 0;
  logic [7:0] rxd8 = '0;
  bit         q8[$];
  assign b8.miso = (mode == 0) ? b8.mosi : (mode == 1) ? 1'b1 :
                   (r8 < 8) ? slave_w[7 - r8] : 1'b0;
  assign b16.miso = b16.mosi;

  // Observes the 8-bit SPI pins and records per-transfer facts.
  logic ps8 = 1'b0, pm8 = 1'b0, pc8 = 1'b1;
  logic [7:0] prx8 = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b8.sclk && !ps8) begin r8++; q8.push_back(b8.mosi); if (b8.cs_n) viol++; end
      if (b8.sclk && ps8 && b8.mosi !== pm8) viol++;
      if (!pc8 && b8.cs_n && !b8.done) viol++;
      if (b8.rx_data !== prx8 && !b8.done) viol++;
      if (b8.done) begin d8++; rxd8 = b8.rx_data; if (b8.busy || !b8.cs_n) viol++; end
    end
    ps8 = b8.sclk; pm8 = b8.mosi; pc8 = b8.cs_n; prx8 = b8.rx_data;
  end

  int          r16 = 0, d16 = 0;
  logic [15:0] rxd16 = '0;
  bit          q16[$];
  logic        ps16 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (b16.sclk && !ps16) begin r16++; q16.push_back(b16.mosi); end
      if (b16.done) begin d16++; rxd16 = b16.rx_data; end
    end
    ps16 = b16.sclk;
  end

  task automatic clear_mon();
    r8 = 0; d8 = 0; viol = 0; q8.delete();
  endtask

  function automatic logic [15:0] bits8();
    logic [15:0] v = '0;
    foreach (q8[i]) v = {v[14:0], q8[i]};
    return v;
  endfunction

  task automatic kick(input logic [7:0] tx);
    @(negedge clk); b8.tx_data = tx; b8.start = 1'b1;
    @(negedge clk); b8.start = 1'b0; b8.tx_data = 8'($urandom);
  endtask

  task automatic wait_done8(input int budget);
    int n = 0;
    while (b8.done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (n >= budget) begin fails++; $display("FAIL done8_timeout: no done within %0d cycles", budget); end
    #1;
  endtask

  task automatic wait_rises8(input int k);
    int n = 0;
    while (r8 < k && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (n >= 400) begin fails++; $display("FAIL rise_timeout: got %0d rises want %0d", r8, k); end
  endtask

  task automatic test_reset();
    b8.start = 0; b8.tx_data = '0; b16.start = 0; b16.tx_data = '0; rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (b8.cs_n !== 1'b1) begin fails++; $display("FAIL rst_cs_n: got %b want 1", b8.cs_n); end
    checks++; if (b8.sclk !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b want 0", b8.sclk); end
    checks++; if (b8.mosi !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b want 0", b8.mosi); end
    checks++; if (b8.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", b8.busy); end
    checks++; if (b8.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", b8.done); end
    checks++; if (b8.rx_data !== 8'h00) begin fails++; $display("FAIL rst_rx: got %h want 00", b8.rx_data); end
    checks++; if (b16.rx_data !== 16'h0) begin fails++; $display("FAIL rst_rx16: got %h want 0000", b16.rx_data); end
    rst_n = 1;
    repeat (12) @(negedge clk);
    checks++; if (b8.cs_n !== 1'b1 || r8 !== 0) begin fails++; $display("FAIL idle_no_xfer: cs_n %b rises %0d want 1/0", b8.cs_n, r8); end
  endtask

  task automatic test_tied_high();
    @(negedge clk); rst_n = 0; repeat (2) @(negedge clk); rst_n = 1;
    clear_mon(); mode = 1;
    kick(8'h3C);
    checks++; if (b8.busy !== 1'b1 || b8.cs_n !== 1'b0) begin fails++; $display("FAIL accept: busy %b cs_n %b want 1/0", b8.busy, b8.cs_n); end
    checks++; if (b8.rx_data !== 8'h00) begin fails++; $display("FAIL rx_hold0: got %h want 00", b8.rx_data); end
    wait_done8(400);
    checks++; if (r8 !== 8) begin fails++; $display("FAIL 3c_rises: got %0d want 8", r8); end
    checks++; if (bits8() !== 16'h003C) begin fails++; $display("FAIL 3c_mosi: got %h want 3c", bits8()); end
    checks++; if (rxd8 !== 8'hFF) begin fails++; $display("FAIL 3c_rx: got %h want ff", rxd8); end
    checks++; if (viol !== 0) begin fails++; $display("FAIL 3c_protocol: %0d violations want 0", viol); end
  endtask

  task automatic test_loopback();
    clear_mon(); mode = 0;
    kick(8'hA5);
    wait_done8(400);
    checks++; if (b8.cs_n !== 1'b1 || b8.busy !== 1'b0) begin fails++; $display("FAIL a5_done_cycle: cs_n %b busy %b want 1/0", b8.cs_n, b8.busy); end
    checks++; if (r8 !== 8) begin fails++; $display("FAIL a5_rises: got %0d want 8", r8); end
    checks++; if (bits8() !== 16'h00A5) begin fails++; $display("FAIL a5_mosi: got %h want a5", bits8()); end
    checks++; if (rxd8 !== 8'hA5) begin fails++; $display("FAIL a5_rx: got %h want a5", rxd8); end
    repeat (12) @(negedge clk);
    checks++; if (d8 !== 1 || viol !== 0) begin fails++; $display("FAIL a5_once: done %0d viol %0d want 1/0", d8, viol); end
  endtask

  task automatic test_start_while_busy();
    clear_mon(); mode = 0;
    kick(8'h81);
    wait_rises8(3);
    @(negedge clk); @(negedge clk); b8.start = 1; b8.tx_data = 8'hFF;
    @(negedge clk); b8.start = 0;
    wait_done8(400);
    repeat (20) @(negedge clk);
    checks++; if (d8 !== 1) begin fails++; $display("FAIL busy_start_done: got %0d want 1", d8); end
    checks++; if (r8 !== 8) begin fails++; $display("FAIL busy_start_rises: got %0d want 8", r8); end
    checks++; if (rxd8 !== 8'h81) begin fails++; $display("FAIL busy_start_rx: got %h want 81", rxd8); end
    checks++; if (b8.cs_n !== 1'b1) begin fails++; $display("FAIL busy_start_queued: cs_n %b want 1", b8.cs_n); end
  endtask

  task automatic test_reset_mid();
    clear_mon(); mode = 0;
    kick(8'hC3);
    wait_rises8(3);
    @(negedge clk); rst_n = 0; #1;
    checks++; if (b8.cs_n !== 1'b1 || b8.sclk !== 1'b0 || b8.busy !== 1'b0) begin fails++; $display("FAIL midrst: cs_n %b sclk %b busy %b want 1/0/0", b8.cs_n, b8.sclk, b8.busy); end
    checks++; if (b8.rx_data !== 8'h00) begin fails++; $display("FAIL midrst_rx: got %h want 00", b8.rx_data); end
    @(negedge clk); @(negedge clk); rst_n = 1;
    repeat (30) @(negedge clk);
    checks++; if (d8 !== 0) begin fails++; $display("FAIL midrst_done: got %0d want 0", d8); end
    clear_mon();
    kick(8'h5A);
    wait_done8(400);
    checks++; if (rxd8 !== 8'h5A || r8 !== 8) begin fails++; $display("FAIL after_rst: rx %h rises %0d want 5a/8", rxd8, r8); end
  endtask

  task automatic test_back_to_back();
    int gap = 1;
    clear_mon(); mode = 0;
    @(negedge clk); b8.tx_data = 8'h12; b8.start = 1;
    wait_done8(400);
    checks++; if (rxd8 !== 8'h12) begin fails++; $display("FAIL b2b_rx1: got %h want 12", rxd8); end
    b8.tx_data = 8'h34;
    while (b8.cs_n === 1'b1 && gap < 20) begin @(negedge clk); if (b8.cs_n === 1'b1) gap++; end
    checks++; if (gap !== 2) begin fails++; $display("FAIL b2b_gap: cs_n high %0d clk want 2", gap); end
    wait_done8(400);
    b8.start = 0;
    checks++; if (rxd8 !== 8'h34 || d8 !== 2) begin fails++; $display("FAIL b2b_rx2: rx %h done %0d want 34/2", rxd8, d8); end
    checks++; if (bits8() !== 16'h1234 || r8 !== 16) begin fails++; $display("FAIL b2b_mosi: got %h rises %0d want 1234/16", bits8(), r8); end
    repeat (20) @(negedge clk);
    checks++; if (d8 !== 2 || viol !== 0) begin fails++; $display("FAIL b2b_stop: done %0d viol %0d want 2/0", d8, viol); end
  endtask

  task automatic test_random();
    logic [7:0] tx;
    for (int k = 0; k < 8; k++) begin
      half = $urandom_range(2, 4);
      repeat (10) @(negedge clk);
      clear_mon(); mode = 2;
      tx = 8'($urandom); slave_w = 8'($urandom);
      kick(tx);
      wait_done8(600);
      checks++; if (bits8() !== {8'h00, tx} || r8 !== 8) begin fails++; $display("FAIL rnd_mosi[%0d]: got %h rises %0d want %h/8", k, bits8(), r8, tx); end
      checks++; if (rxd8 !== slave_w) begin fails++; $display("FAIL rnd_rx[%0d]: got %h want %h", k, rxd8, slave_w); end
      checks++; if (viol !== 0) begin fails++; $display("FAIL rnd_protocol[%0d]: %0d violations want 0", k, viol); end
    end
    half = 2; mode = 0;
  endtask

  task automatic test_width16();
    logic [15:0] w [2];
    logic [15:0] got;
    int n;
    w[0] = 16'hBEEF; w[1] = 16'($urandom);
    for (int k = 0; k < 2; k++) begin
      r16 = 0; d16 = 0; q16.delete();
      @(negedge clk); b16.tx_data = w[k]; b16.start = 1;
      @(negedge clk); b16.start = 0; b16.tx_data = 16'($urandom);
      n = 0;
      while (b16.done !== 1'b1 && n < 800) begin @(negedge clk); n++; end
      #1;
      got = '0;
      foreach (q16[i]) got = {got[14:0], q16[i]};
      checks++; if (n >= 800) begin fails++; $display("FAIL w16_timeout[%0d]: no done", k); end
      checks++; if (r16 !== 16) begin fails++; $display("FAIL w16_rises[%0d]: got %0d want 16", k, r16); end
      checks++; if (rxd16 !== w[k] || got !== w[k]) begin fails++; $display("FAIL w16_data[%0d]: rx %h mosi %h want %h", k, rxd16, got, w[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_tied_high();
    test_loopback();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
